// File: rtl/ula_pkg.sv
// Shared ULA definitions: datapath width, divider iteration count and FSM encoding.
package ula_pkg;

  localparam int unsigned LARGURA   = 8;
  localparam int unsigned ITERACOES = 8;
  localparam logic [LARGURA-1:0] DIV_ZERO_Q = 8'hFF;

  typedef enum logic [1:0] {
    ESTADO_IDLE = 2'd0,
    ESTADO_CALC = 2'd1,
    ESTADO_DONE = 2'd2
  } estado_t;

endpackage

// File: rtl/subtrator_8bits.sv
// 8-bit unsigned subtractor: S = A - B, C_out is the borrow (set when A < B).
module subtrator_8bits
  import ula_pkg::*;
(
  input  logic [LARGURA-1:0] A,
  input  logic [LARGURA-1:0] B,
  output logic [LARGURA-1:0] S,
  output logic               C_out
);

  logic [LARGURA:0] diff;

  always_comb begin
    diff  = {1'b0, A} - {1'b0, B};
    S     = diff[LARGURA-1:0];
    C_out = diff[LARGURA];
  end

endmodule

// File: rtl/divisor_sequencial_8bits.sv
// Sequential 8-bit restoring divider: one quotient bit per clock on top of subtrator_8bits,
// with a start/busy/done handshake and a sticky divide-by-zero flag.
module divisor_sequencial_8bits
  import ula_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LARGURA-1:0]   A,
  input  logic [LARGURA-1:0]   B,
  output logic [LARGURA-1:0]   Q,
  output logic [LARGURA-1:0]   R,
  output logic                 busy,
  output logic                 done,
  output logic                 div_zero
);

  estado_t            estado;
  logic [LARGURA-1:0] dividendo;
  logic [LARGURA-1:0] divisor;
  // Before every step the partial remainder is < 128, so 7 bits hold it; the final
  // (possibly wider) remainder is taken straight from resto_prox into R.
  logic [LARGURA-2:0] parcial;
  logic [2:0]         contador;

  logic [LARGURA-1:0] deslocado;
  logic [LARGURA-1:0] diferenca;
  logic               emprestimo;
  logic [LARGURA-1:0] resto_prox;
  logic [LARGURA-1:0] dividendo_prox;

  always_comb begin
    deslocado = {parcial, dividendo[LARGURA-1]};
  end

  subtrator_8bits u_subtrator (
    .A     (deslocado),
    .B     (divisor),
    .S     (diferenca),
    .C_out (emprestimo)
  );

  // Restore on borrow: keep the shifted value and shift in a 0 quotient bit.
  always_comb begin
    resto_prox     = emprestimo ? deslocado : diferenca;
    dividendo_prox = {dividendo[LARGURA-2:0], ~emprestimo};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado    <= ESTADO_IDLE;
      dividendo <= '0;
      divisor   <= '0;
      parcial   <= '0;
      contador  <= '0;
      Q         <= '0;
      R         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      unique case (estado)
        ESTADO_IDLE: begin
          if (start) begin
            if (B != '0) begin
              dividendo <= A;
              divisor   <= B;
              parcial   <= '0;
              contador  <= '0;
              busy      <= 1'b1;
              estado    <= ESTADO_CALC;
            end else begin
              Q        <= DIV_ZERO_Q;
              R        <= A;
              div_zero <= 1'b1;
              done     <= 1'b1;
              estado   <= ESTADO_DONE;
            end
          end
        end
        ESTADO_CALC: begin
          dividendo <= dividendo_prox;
          parcial   <= resto_prox[LARGURA-2:0];
          contador  <= contador + 3'd1;
          if (contador == 3'(ITERACOES - 1)) begin
            Q        <= dividendo_prox;
            R        <= resto_prox;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            estado   <= ESTADO_DONE;
          end
        end
        ESTADO_DONE: begin
          done   <= 1'b0;
          estado <= ESTADO_IDLE;
        end
        default: begin
          busy   <= 1'b0;
          done   <= 1'b0;
          estado <= ESTADO_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_sequencial_8bits.sv
// Scoreboard bench for divisor_sequencial_8bits: expected {Q,R,div_zero} queued at stimulus,
// popped and compared on every done pulse.
module tb_divisor_sequencial_8bits;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic [7:0] Q;
  logic [7:0] R;
  logic       busy;
  logic       done;
  logic       div_zero;

  int unsigned errors;
  int unsigned checks;
  int unsigned done_count;
  logic [16:0] sb_q[$];

  divisor_sequencial_8bits dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .A        (A),
    .B        (B),
    .Q        (Q),
    .R        (R),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] model(input logic [7:0] a, input logic [7:0] b);
    if (b == 8'd0) return {8'hFF, a, 1'b1};
    return {8'(a / b), 8'(a % b), 1'b0};
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_count++;
      if (sb_q.size() == 0) begin
        check_eq("spurious_done", 32'd1, 32'd0);
      end else begin
        check_eq("result", {15'd0, Q, R, div_zero}, {15'd0, sb_q.pop_front()});
      end
    end
  end

  // One start pulse, then measure busy cycles and the negedge index at which done appears.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int busy_cycles);
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    sb_q.push_back(model(a, b));
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    busy_cycles = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) check_eq("timeout", 32'd0, 32'd1);
    @(negedge clk);
    check_eq("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  int lat;
  int bcy;
  int dc0;

  initial begin
    errors = 0;
    checks = 0;
    done_count = 0;
    rst_n = 1'b0;
    start = 1'b0;
    A = 8'd0;
    B = 8'd0;
    repeat (3) @(posedge clk);
    #1 check_eq("reset_state", {20'd0, Q, R, busy, done, div_zero}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Main case with latency and busy width.
    run_op(8'd200, 8'd7, lat, bcy);
    check_eq("lat_200_7", lat, 32'd9);
    check_eq("busy_200_7", bcy, 32'd8);

    // Boundaries.
    run_op(8'd255, 8'd1, lat, bcy);
    run_op(8'd5, 8'd9, lat, bcy);
    run_op(8'd255, 8'd255, lat, bcy);
    run_op(8'd0, 8'd13, lat, bcy);
    run_op(8'd130, 8'd200, lat, bcy);

    // Divide by zero.
    run_op(8'd77, 8'd0, lat, bcy);
    check_eq("lat_div0", lat, 32'd1);
    check_eq("busy_div0", bcy, 32'd0);

    // Reset mid-operation.
    @(negedge clk);
    A = 8'd200;
    B = 8'd7;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1 check_eq("reset_mid_op", {20'd0, Q, R, busy, done, div_zero}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    run_op(8'd20, 8'd3, lat, bcy);
    check_eq("lat_after_reset", lat, 32'd9);

    // Start held high with operands changing after each acceptance.
    dc0 = done_count;
    @(negedge clk);
    A = 8'd100;
    B = 8'd10;
    start = 1'b1;
    sb_q.push_back(model(8'd100, 8'd10));
    @(posedge clk);
    #1 A = 8'd50;
    B = 8'd7;
    sb_q.push_back(model(8'd50, 8'd7));
    repeat (10) @(posedge clk);
    #1 A = 8'd9;
    B = 8'd4;
    sb_q.push_back(model(8'd9, 8'd4));
    repeat (10) @(posedge clk);
    #1 start = 1'b0;
    A = 8'd0;
    B = 8'd0;
    repeat (15) @(negedge clk);
    check_eq("held_start_dones", done_count - dc0, 32'd3);

    // Operand change and start pulse during CALC must not disturb the result.
    dc0 = done_count;
    @(negedge clk);
    A = 8'd250;
    B = 8'd130;
    start = 1'b1;
    sb_q.push_back(model(8'd250, 8'd130));
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 A = 8'd1;
    B = 8'd1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("mid_calc_dones", done_count - dc0, 32'd1);

    check_eq("scoreboard_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
